obi_mem_responder: RTL and testbench
====================================

# obi_mem_responder

Parametrised OBI memory responder for the CV32E40X core testbench; a next-generation replacement for the fixed single-cycle RAM model behind one core bus port (instruction or data). It accepts OBI requests and services them from a byte-addressed backing store plus memory-mapped test-status registers. Responses return in order after a configurable latency, and up to a configurable number of transactions may be outstanding. Grant can optionally be stalled pseudo-randomly for stress testing.

## Interface
- DATA_WIDTH, 32: bus data width; multiple of 8.
- ADDR_WIDTH, 32: bus address width.
- RAM_ADDR_WIDTH, 20: backing store size is 2**RAM_ADDR_WIDTH bytes, based at address 0.
- MAX_OUTSTANDING, 2: response FIFO depth; must be ≥1.
- RESP_LATENCY, 1: cycles from grant to rvalid; must be ≥1.
- STATUS_ADDR, 32'h2000_0000: test-status register address.
- EXIT_ADDR, 32'h2000_0004: exit-value register address.
- STALL_SEED, 16'hACE1: LFSR seed for random stall; must be nonzero.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- addr_i  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored (word-aligned).
- we_i  in  1  write enable.
- be_i  in  DATA_WIDTH/8  byte enables.
- wdata_i  in  DATA_WIDTH  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  DATA_WIDTH  read data; 0 for writes.
- err_o  out  1  response error; qualified by rvalid_o.
- tests_passed_o  out  1  sticky pass flag.
- tests_failed_o  out  1  sticky fail flag.
- exit_valid_o  out  1  sticky exit flag.
- exit_value_o  out  32  value written to EXIT_ADDR.

## Operation
- Handshake: transfer occurs in the cycle where req_i && gnt_o. gnt_o = req_i && (count < MAX_OUTSTANDING) && !stall, combinational.
- At transfer, the address is decoded, the access performed, and the entry {rdata, err, age=0} pushed to the response FIFO.
- RAM (addr < 2**RAM_ADDR_WIDTH): write updates only bytes with be_i set, committed at the grant edge. Read returns the full word as it was before the same-edge write. A subsequently granted read sees the new data.
- STATUS_ADDR write: wdata==123456789 sets tests_passed_o. wdata==1 sets tests_failed_o. Any other value is ignored.
- EXIT_ADDR write: exit_value_o <= wdata[31:0], exit_valid_o <= 1. A later write overwrites the value.
- MMIO reads return 0 with err=0.
- Any other address: err=1, rdata=0, write dropped, no state change.
- Response FIFO: every valid entry's age increments each cycle, saturating at RESP_LATENCY. The head pops when its age == RESP_LATENCY, driving rvalid_o=1, rdata_o and err_o for exactly that cycle. There is no rvalid backpressure (OBI).
- Full: when count == MAX_OUTSTANDING, gnt_o=0. A push in the same cycle as a pop is allowed only if count < MAX_OUTSTANDING before the edge. gnt does not look ahead to the pop.
- Status flags are sticky until reset. Passed and failed may both be set.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, tests_passed_o=0, tests_failed_o=0, exit_valid_o=0, exit_value_o=0. FIFO is empty; LFSR is loaded with STALL_SEED.
- Backing store is not reset; contents survive rst_ni.
- Reset mid-operation flushes all outstanding responses; none are delivered after reset.
- Response for a grant in cycle N: rvalid_o is high in cycle N+RESP_LATENCY. Responses are strictly in grant order.
- Throughput: back-to-back grants every cycle are sustained iff MAX_OUTSTANDING ≥ RESP_LATENCY+1. Otherwise gnt_o drops while the FIFO is full.
- Status and exit outputs update at the grant edge, visible in cycle N+1.

## Configuration
- OBI_MEM_RESPONDER_RANDOM_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - stall = (lfsr[1:0]==2'b00), giving roughly 25% grant suppression.
  - Stall never affects in-flight responses.
- Not defined: stall is tied to 0, no LFSR is instantiated, and gnt_o depends only on req_i and FIFO occupancy.

## Test plan
- Write 32'hDEADBEEF to 0x100 with be=4'b1111, then read 0x100 with RESP_LATENCY=1 → rdata=32'hDEADBEEF, rvalid exactly 1 cycle after the read grant, err=0.
- Partial write: write 32'h0000_00AA with be=4'b0001 over 32'hDEADBEEF at 0x100, then read → 32'hDEADBEAA.
- RESP_LATENCY=3, MAX_OUTSTANDING=2, req held high for 6 reads → gnt pattern 1,1,0,0,1,1. rvalid arrives 3 cycles after each grant, in order.
- Write 123456789 to STATUS_ADDR → tests_passed_o=1 next cycle. Write 1 → tests_failed_o=1, tests_passed_o stays 1. Write 7 to EXIT_ADDR → exit_valid_o=1, exit_value_o=7.
- Read 0x0020_0000 with RAM_ADDR_WIDTH=20 → err_o=1, rdata_o=0. Write to the same address → err_o=1, RAM unchanged.
- Assert rst_ni with 2 responses outstanding → no rvalid after reset; all outputs 0. A RAM read after reset returns the pre-reset data. With the macro defined, gnt is low in some cycles while req is high, and all responses still match a reference model.

Source files
------------

// File: rtl/obi_mem_responder.sv
// obi_mem_responder: OBI memory responder for the core testbench.
// Services OBI requests from a byte-addressed backing store and two
// test-status registers. Responses return in grant order after a fixed
// latency, with a bounded number of transactions outstanding.
// Optional feature: define OBI_MEM_RESPONDER_RANDOM_STALL_EN to suppress
// grant pseudo-randomly (16-bit LFSR) for bus stress testing.
module obi_mem_responder #(
  parameter int              DATA_WIDTH      = 32,
  parameter int              ADDR_WIDTH      = 32,
  parameter int              RAM_ADDR_WIDTH  = 20,
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              RESP_LATENCY    = 1,
  parameter logic [31:0]     STATUS_ADDR     = 32'h2000_0000,
  parameter logic [31:0]     EXIT_ADDR       = 32'h2000_0004,
  parameter logic [15:0]     STALL_SEED      = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    tests_passed_o,
  output logic                    tests_failed_o,
  output logic                    exit_valid_o,
  output logic [31:0]             exit_value_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = RAM_ADDR_WIDTH - OFF;
  localparam int WORDS = 2 ** IDX_W;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int AGE_W = $clog2(RESP_LATENCY + 1);

  localparam logic [CNT_W-1:0]      MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0]      PTR_LAST   = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [AGE_W-1:0]      AGE_DONE   = AGE_W'(RESP_LATENCY);
  localparam logic [AGE_W-1:0]      AGE_FIRST  = AGE_W'(1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] STATUS_A   = ADDR_WIDTH'(STATUS_ADDR) & ALIGN_MASK;
  localparam logic [ADDR_WIDTH-1:0] EXIT_A     = ADDR_WIDTH'(EXIT_ADDR) & ALIGN_MASK;
  localparam logic [DATA_WIDTH-1:0] PASS_CODE  = DATA_WIDTH'(123456789);
  localparam logic [DATA_WIDTH-1:0] FAIL_CODE  = DATA_WIDTH'(1);

  // Backing store; deliberately never reset so contents survive rst_ni.
  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Response FIFO: data slots plus per-slot control (valid, age).
  logic [DATA_WIDTH-1:0]      rdata_q [MAX_OUTSTANDING];
  logic                       err_q   [MAX_OUTSTANDING];
  logic [AGE_W-1:0]           age_q   [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] slot_vld_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;

  logic                  stall;
  logic                  push;
  logic                  pop;
  logic                  is_ram;
  logic                  is_status;
  logic                  is_exit;
  logic [IDX_W-1:0]      ram_idx;
  logic [ADDR_WIDTH-1:0] addr_aligned;
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic                  acc_err;

`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign stall   = (lfsr_q[1:0] == 2'b00);

  // Free-running Fibonacci LFSR (taps 16,14,13,11) driving grant suppression.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= STALL_SEED;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  assign stall = 1'b0;
`endif

  // Grant never looks ahead to a same-cycle pop; it only sees current occupancy.
  assign gnt_o = req_i && (count_q < MAX_CNT) && !stall;
  assign push  = gnt_o;
  assign pop   = (count_q != '0) && (age_q[rd_ptr_q] == AGE_DONE);

  assign addr_aligned = addr_i & ALIGN_MASK;
  assign is_ram       = ((addr_i >> RAM_ADDR_WIDTH) == '0);
  assign is_status    = (addr_aligned == STATUS_A);
  assign is_exit      = (addr_aligned == EXIT_A);
  assign ram_idx      = addr_i[RAM_ADDR_WIDTH-1:OFF];

  // Address decode and read data for the access being granted this cycle.
  always_comb begin
    acc_rdata = '0;
    acc_err   = 1'b0;
    if (is_ram) begin
      if (!we_i) acc_rdata = mem[ram_idx];
    end else if (!(is_status || is_exit)) begin
      acc_err = 1'b1;
    end
  end

  // Byte-enabled RAM write, committed at the grant edge.
  always_ff @(posedge clk_i) begin
    if (push && we_i && is_ram) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_i[b]) mem[ram_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Response payload capture; data slots are not reset, slot_vld_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      rdata_q[wr_ptr_q] <= acc_rdata;
      err_q[wr_ptr_q]   <= acc_err;
    end
  end

  // FIFO control: pointers, occupancy, per-slot valid and saturating age.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      slot_vld_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) age_q[i] <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A slot is pushed with age 1 so the head pops exactly RESP_LATENCY
      // cycles after its grant cycle.
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (push && (wr_ptr_q == PTR_W'(i))) begin
          slot_vld_q[i] <= 1'b1;
          age_q[i]      <= AGE_FIRST;
        end else if (pop && (rd_ptr_q == PTR_W'(i))) begin
          slot_vld_q[i] <= 1'b0;
        end else if (slot_vld_q[i] && (age_q[i] < AGE_DONE)) begin
          age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end
  end

  // Sticky test-status and exit registers, updated at the grant edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
    end else if (push && we_i) begin
      if (is_status && (wdata_i == PASS_CODE)) tests_passed_o <= 1'b1;
      if (is_status && (wdata_i == FAIL_CODE)) tests_failed_o <= 1'b1;
      if (is_exit) begin
        exit_valid_o <= 1'b1;
        exit_value_o <= wdata_i[31:0];
      end
    end
  end

  assign rvalid_o = pop;
  assign rdata_o  = pop ? rdata_q[rd_ptr_q] : '0;
  assign err_o    = pop && err_q[rd_ptr_q];

endmodule

// File: tb/tb_obi_mem_responder.sv
// Testbench for obi_mem_responder: two instances (latency 1 and latency 3),
// directed stimulus with a response scoreboard per instance.
module tb_obi_mem_responder;

  localparam logic [31:0] STATUS_A = 32'h2000_0000;
  localparam logic [31:0] EXIT_A   = 32'h2000_0004;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;

  logic        req    [2];
  logic        we     [2];
  logic        gnt    [2];
  logic        rvalid [2];
  logic        err    [2];
  logic        passed [2];
  logic        failed [2];
  logic        xvalid [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic [31:0] xvalue [2];
  logic [3:0]  be     [2];

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] mem_m0 [int];
  logic [31:0] mem_m1 [int];
  int          rv_seen [2];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obi_mem_responder #(.RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]),
    .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .tests_passed_o(passed[0]), .tests_failed_o(failed[0]),
    .exit_valid_o(xvalid[0]), .exit_value_o(xvalue[0])
  );

  obi_mem_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]),
    .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .tests_passed_o(passed[1]), .tests_failed_o(failed[1]),
    .exit_valid_o(xvalid[1]), .exit_value_o(xvalue[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model of one access; updates the bench's copy of the RAM.
  task automatic predict(input int s, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, output exp_t e);
    logic [31:0] old;
    int          k;
    k = int'(a >> 2);
    e.rdata = '0;
    e.err   = 1'b0;
    e.due   = cyc + ((s == 0) ? 1 : 3);
    if (a < 32'h0010_0000) begin
      old = '0;
      if (s == 0 && mem_m0.exists(k)) old = mem_m0[k];
      if (s == 1 && mem_m1.exists(k)) old = mem_m1[k];
      if (w) begin
        for (int j = 0; j < 4; j++) if (b[j]) old[8*j +: 8] = d[8*j +: 8];
        if (s == 0) mem_m0[k] = old;
        else        mem_m1[k] = old;
      end else begin
        e.rdata = old;
      end
    end else if (((a & ~32'h3) != STATUS_A) && ((a & ~32'h3) != EXIT_A)) begin
      e.err = 1'b1;
    end
  endtask

  task automatic push_exp(input int s, input exp_t e);
    if (s == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic mon(input int s);
    exp_t e;
    logic have;
    if (rvalid[s]) begin
      rv_seen[s]++;
      have = (s == 0) ? (qa.size() > 0) : (qb.size() > 0);
      chk($sformatf("rsp%0d_expected", s), {31'b0, have}, 32'd1);
      if (have) begin
        if (s == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk($sformatf("rsp%0d_rdata", s), rdata[s], e.rdata);
        chk($sformatf("rsp%0d_err", s), {31'b0, err[s]}, {31'b0, e.err});
        chk($sformatf("rsp%0d_cycle", s), cyc, e.due);
      end
    end
  endtask

  // Response scoreboard for both instances, sampled on the falling edge.
  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic xfer(input int s, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
    exp_t e;
    int   wt;
    @(posedge clk); #1;
    req[s] = 1'b1; we[s] = w; addr[s] = a; be[s] = b; wdata[s] = d;
    wt = 0;
    @(negedge clk);
    while (!gnt[s] && wt < 50) begin
      wt++;
      @(negedge clk);
    end
    chk($sformatf("grant%0d", s), {31'b0, gnt[s]}, 32'd1);
    if (gnt[s]) begin
      predict(s, w, a, b, d, e);
      push_exp(s, e);
    end
    @(posedge clk); #1;
    req[s] = 1'b0;
  endtask

  // Holds req high for n reads cycling over span words from base; records grant pattern.
  task automatic burst(input int s, input int n, input logic [31:0] base, input int span,
                       output logic [31:0] pat, output int cycles);
    exp_t e;
    int   got;
    int   k;
    logic g;
    got = 0; k = 0; pat = '0;
    @(posedge clk); #1;
    req[s] = 1'b1; we[s] = 1'b0; be[s] = 4'hF; wdata[s] = '0; addr[s] = base;
    while (got < n && k < 400) begin
      @(negedge clk);
      g = gnt[s];
      pat = {pat[30:0], g};
      if (g) begin
        predict(s, 1'b0, addr[s], 4'hF, 32'h0, e);
        push_exp(s, e);
        got++;
      end
      k++;
      @(posedge clk); #1;
      if (g) addr[s] = base + 32'(4 * (got % span));
    end
    req[s] = 1'b0;
    cycles = k;
    chk($sformatf("burst%0d_grants", s), got, n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((qa.size() + qb.size()) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    chk("drain", qa.size() + qb.size(), 0);
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_gnt"},    {31'b0, gnt[s]},    32'd0);
    chk({tag, "_rvalid"}, {31'b0, rvalid[s]}, 32'd0);
    chk({tag, "_rdata"},  rdata[s],           32'd0);
    chk({tag, "_err"},    {31'b0, err[s]},    32'd0);
    chk({tag, "_passed"}, {31'b0, passed[s]}, 32'd0);
    chk({tag, "_failed"}, {31'b0, failed[s]}, 32'd0);
    chk({tag, "_xvalid"}, {31'b0, xvalid[s]}, 32'd0);
    chk({tag, "_xvalue"}, xvalue[s],          32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pat;
    int          cy;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; be[s] = '0; wdata[s] = '0;
      rv_seen[s] = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle(0, "rst_l1");
    chk_idle(1, "rst_l3");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full-word write then read, partial write then read
    xfer(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h100, 4'hF, 32'h0);
    xfer(0, 1'b1, 32'h100, 4'b0001, 32'h0000_00AA);
    xfer(0, 1'b0, 32'h100, 4'hF, 32'h0);
    drain();

    // Status and exit registers
    xfer(0, 1'b1, STATUS_A, 4'hF, 32'd123456789);
    chk("passed_set", {31'b0, passed[0]}, 32'd1);
    chk("failed_clear", {31'b0, failed[0]}, 32'd0);
    xfer(0, 1'b1, STATUS_A, 4'hF, 32'd1);
    chk("failed_set", {31'b0, failed[0]}, 32'd1);
    chk("passed_sticky", {31'b0, passed[0]}, 32'd1);
    chk("xvalid_before", {31'b0, xvalid[0]}, 32'd0);
    xfer(0, 1'b1, EXIT_A, 4'hF, 32'd7);
    chk("xvalid_set", {31'b0, xvalid[0]}, 32'd1);
    chk("xvalue_7", xvalue[0], 32'd7);
    xfer(0, 1'b1, EXIT_A, 4'hF, 32'd9);
    chk("xvalue_9", xvalue[0], 32'd9);
    xfer(0, 1'b0, STATUS_A, 4'hF, 32'h0);

    // Out-of-range accesses error out and leave RAM untouched
    xfer(0, 1'b1, 32'h0, 4'hF, 32'h1111_1111);
    xfer(0, 1'b0, 32'h0020_0000, 4'hF, 32'h0);
    xfer(0, 1'b1, 32'h0020_0000, 4'hF, 32'h2222_2222);
    xfer(0, 1'b0, 32'h0, 4'hF, 32'h0);
    drain();

    // Back-to-back reads at latency 1 with two outstanding
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h400 + 32'(4 * i), 4'hF, 32'hA500_0000 + 32'(i));
    burst(0, 4, 32'h400, 4, pat, cy);
`ifndef OBI_MEM_RESPONDER_RANDOM_STALL_EN
    chk("l1_sustain_pattern", pat & 32'hF, 32'hF);
`endif
    drain();

    // Latency 3 with two outstanding: grant stalls while full
    for (int i = 0; i < 6; i++) xfer(1, 1'b1, 32'h800 + 32'(4 * i), 4'hF, 32'hB000_0000 + 32'(i));
    drain();
    burst(1, 6, 32'h800, 6, pat, cy);
`ifndef OBI_MEM_RESPONDER_RANDOM_STALL_EN
    chk("l3_gnt_pattern", pat & 32'h3F, 32'b110011);
`endif
    drain();

    // Reset with responses outstanding flushes them
    burst(1, 2, 32'h804, 2, pat, cy);
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    rv_seen[0] = 0;
    rv_seen[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle(1, "midrst_l3");
    chk_idle(0, "midrst_l1");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_rvalid_after_reset_l3", rv_seen[1], 0);
    chk("no_rvalid_after_reset_l1", rv_seen[0], 0);

    // Backing store survives reset
    xfer(1, 1'b0, 32'h804, 4'hF, 32'h0);
    xfer(0, 1'b0, 32'h100, 4'hF, 32'h0);
    drain();

`ifdef OBI_MEM_RESPONDER_RANDOM_STALL_EN
    // Random stall: some cycles withhold grant, responses still match the model
    burst(0, 24, 32'h400, 4, pat, cy);
    chk("stall_seen", {31'b0, (cy > 24)}, 32'd1);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
